// File: rtl/seq_alu_if.sv
// seq_alu request/response bundle.
// master drives the request side, slave owns the result side.
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [3:0]         operation;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] Result;
  logic [WIDTH-1:0]   Remainder;
  logic               C_out;
  logic               Z;
  logic               N;
  logic               C;
  logic               V;
  logic               div_by_zero;

  modport master (
    output start, operation, A, B,
    input  busy, done, Result, Remainder,
    input  C_out, Z, N, C, V, div_by_zero
  );

  modport slave (
    input  start, operation, A, B,
    output busy, done, Result, Remainder,
    output C_out, Z, N, C, V, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arith/logic/shift,
// iterative shift-add multiply and restoring divide.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_XNOR = 4'd9;
  localparam logic [3:0] OP_SLL  = 4'd10;
  localparam logic [3:0] OP_SRL  = 4'd11;
  localparam logic [3:0] OP_SRA  = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;

  logic [W2-1:0]    res_q, res_f;
  logic [WIDTH-1:0] rmd_q, rmd_f;
  logic             cout_q, cout_f;
  logic             z_q, z_f, n_q, n_f;
  logic             c_q, c_f, v_q, v_f;
  logic             dbz_q, dbz_f;
  logic             done_q;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] shr;
  logic [W2-1:0]    prod_s;
  logic [WIDTH-1:0] quo_s;
  logic [SHW-1:0]   sh;
  logic             neg, legal;

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x
  );
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [W2-1:0] sext(
    input logic [WIDTH-1:0] x
  );
    return {{WIDTH{x[WIDTH-1]}}, x};
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, dvs_q};
    unique case (state_q)
      S_IDLE: begin
        // start during the done cycle is dropped
        if (bus.start && !done_q) begin
          op_d    = bus.operation;
          a_d     = bus.A;
          b_d     = bus.B;
          cnt_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, mag(bus.A)};
          mplr_d  = mag(bus.B);
          prod_d  = '0;
          rem_d   = '0;
          quo_d   = mag(bus.A);
          dvs_d   = mag(bus.B);
          if (bus.operation == OP_MUL)
            state_d = S_MUL;
          else if (bus.operation == OP_DIV
                   && bus.B != '0)
            state_d = S_DIV;
          else
            state_d = S_FIN;
        end
      end
      S_MUL: begin
        if (mplr_q[0])
          prod_d = prod_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1))
          state_d = S_FIN;
      end
      S_DIV: begin
        quo_d = {quo_q[WIDTH-2:0], rem_ge};
        rem_d = rem_ge
              ? rem_sh[WIDTH-1:0] - dvs_q
              : rem_sh[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1))
          state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_f  = '0;
    rmd_f  = '0;
    cout_f = 1'b0;
    c_f    = 1'b0;
    v_f    = 1'b0;
    dbz_f  = 1'b0;
    legal  = 1'b1;
    sum    = {1'b0, a_q} + {1'b0, b_q};
    diff   = {1'b0, a_q} - {1'b0, b_q};
    neg    = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    prod_s = neg ? -prod_q : prod_q;
    quo_s  = neg ? -quo_q : quo_q;
    sh     = b_q[SHW-1:0];
    shr    = $signed(a_q) >>> sh;
    unique case (op_q)
      OP_ADD: begin
        res_f  = sext(sum[WIDTH-1:0]);
        cout_f = sum[WIDTH];
        c_f    = sum[WIDTH];
        v_f    = (a_q[WIDTH-1] == b_q[WIDTH-1])
              && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_f = sext(diff[WIDTH-1:0]);
        c_f   = diff[WIDTH];
        v_f   = (a_q[WIDTH-1] != b_q[WIDTH-1])
             && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL: begin
        res_f = prod_s;
        v_f   = !((&prod_s[W2-1:WIDTH-1])
              || !(|prod_s[W2-1:WIDTH-1]));
      end
      OP_DIV: begin
        if (b_q == '0) begin
          dbz_f = 1'b1;
        end else begin
          // MIN/-1 wraps to MIN through quo_s
          res_f = sext(quo_s);
          rmd_f = a_q[WIDTH-1] ? -rem_q : rem_q;
          v_f   = (a_q == {1'b1, {(WIDTH-1){1'b0}}})
               && (&b_q);
        end
      end
      OP_AND:  res_f = sext(a_q & b_q);
      OP_OR:   res_f = sext(a_q | b_q);
      OP_NOR:  res_f = sext(~(a_q | b_q));
      OP_NAND: res_f = sext(~(a_q & b_q));
      OP_XOR:  res_f = sext(a_q ^ b_q);
      OP_XNOR: res_f = sext(~(a_q ^ b_q));
      OP_SLL:  res_f = sext(a_q << sh);
      OP_SRL:  res_f = sext(a_q >> sh);
      OP_SRA:  res_f = sext(shr);
      default: legal = 1'b0;
    endcase
    z_f = legal && (res_f == '0);
    n_f = res_f[W2-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      res_q  <= '0;
      rmd_q  <= '0;
      cout_q <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= (state_q == S_FIN);
      if (state_q == S_FIN) begin
        res_q  <= res_f;
        rmd_q  <= rmd_f;
        cout_q <= cout_f;
        z_q    <= z_f;
        n_q    <= n_f;
        c_q    <= c_f;
        v_q    <= v_f;
        dbz_q  <= dbz_f;
      end
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.Result      = res_q;
  assign bus.Remainder   = rmd_q;
  assign bus.C_out       = cout_q;
  assign bus.Z           = z_q;
  assign bus.N           = n_q;
  assign bus.C           = c_q;
  assign bus.V           = v_q;
  assign bus.div_by_zero = dbz_q;
endmodule
